// File: rtl/spi_responder.sv
// SPI target for 24-bit {R/W, ADDR[6:0], DATA[15:0]} frames, MSB first.
// SPI inputs are oversampled in the clk domain; writes and reads go through
// a simple strobe-based host register port.
module spi_responder #(
  parameter bit CPOL        = 1'b0,
  parameter bit CPHA        = 1'b0,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        SPI_CLK,
  input  logic        SPI_CSB,
  input  logic        SPI_SDI,
  output logic        SPI_SDO,
  output logic        SPI_SDO_OE,
  output logic [6:0]  regAddr,
  output logic        regRdStrobe,
  input  logic [15:0] regRdData,
  output logic        regWrStrobe,
  output logic [15:0] regWrData,
  output logic [7:0]  errorCount,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_WAIT_IDLE,
    S_IDLE,
    S_HEADER,
    S_FETCH,   // read strobe cycle plus one cycle of host latency
    S_DATA
  } state_t;

  state_t state;

  logic [SYNC_STAGES-1:0] clkSync, csbSync, sdiSync;
  logic                   clkPrev, csbPrev;
  logic                   sClk, sCsb, sSdi;
  logic                   leadEdge, trailEdge, sampleEdge, shiftEdge;
  logic                   csbFall, csbRise;

  logic [23:0] rxShift;
  logic [15:0] txShift;
  logic [4:0]  bitCnt;
  logic        overrun;
  logic        isRead;

  // Input synchronizers. CSB resets low so a frame already in progress at
  // reset release is never mistaken for a fresh CSB falling edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      clkSync <= {SYNC_STAGES{CPOL}};
      csbSync <= '0;
      sdiSync <= '0;
      clkPrev <= CPOL;
      csbPrev <= 1'b0;
    end else begin
      clkSync <= {clkSync[SYNC_STAGES-2:0], SPI_CLK};
      csbSync <= {csbSync[SYNC_STAGES-2:0], SPI_CSB};
      sdiSync <= {sdiSync[SYNC_STAGES-2:0], SPI_SDI};
      clkPrev <= clkSync[SYNC_STAGES-1];
      csbPrev <= csbSync[SYNC_STAGES-1];
    end
  end

  assign sClk = clkSync[SYNC_STAGES-1];
  assign sCsb = csbSync[SYNC_STAGES-1];
  assign sSdi = sdiSync[SYNC_STAGES-1];

  // Leading edge leaves the idle level, trailing edge returns to it.
  assign leadEdge   = (clkPrev == CPOL) && (sClk != CPOL);
  assign trailEdge  = (clkPrev != CPOL) && (sClk == CPOL);
  assign sampleEdge = CPHA ? trailEdge : leadEdge;
  assign shiftEdge  = CPHA ? leadEdge  : trailEdge;
  assign csbFall    = csbPrev & ~sCsb;
  assign csbRise    = ~csbPrev & sCsb;

  // Frame FSM: header capture, read fetch, data phase and frame-end checks.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_WAIT_IDLE;
      rxShift     <= '0;
      txShift     <= '0;
      bitCnt      <= '0;
      overrun     <= 1'b0;
      isRead      <= 1'b0;
      regAddr     <= '0;
      regRdStrobe <= 1'b0;
      regWrStrobe <= 1'b0;
      regWrData   <= '0;
      errorCount  <= '0;
      busy        <= 1'b0;
      SPI_SDO     <= 1'b0;
      SPI_SDO_OE  <= 1'b0;
    end else begin
      regWrStrobe <= 1'b0;
      case (state)
        S_WAIT_IDLE: begin
          if (sCsb) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else begin
            busy  <= 1'b1;
          end
        end
        S_IDLE: begin
          if (csbFall) begin
            state      <= S_HEADER;
            bitCnt     <= '0;
            overrun    <= 1'b0;
            isRead     <= 1'b0;
            rxShift    <= '0;
            SPI_SDO_OE <= 1'b1;
            SPI_SDO    <= 1'b0;
            busy       <= 1'b1;
          end
        end
        default: begin
          if (csbRise) begin
            // CSB rising takes priority over any SPI_CLK edge this cycle.
            state       <= S_IDLE;
            busy        <= 1'b0;
            SPI_SDO_OE  <= 1'b0;
            SPI_SDO     <= 1'b0;
            regRdStrobe <= 1'b0;
            if (bitCnt == 5'd24 && !overrun) begin
              if (!isRead) begin
                regWrStrobe <= 1'b1;
                regWrData   <= rxShift[15:0];
              end
            end else if (errorCount != 8'hFF) begin
              errorCount <= errorCount + 8'd1;
            end
          end else begin
            if (sampleEdge) begin
              if (bitCnt == 5'd24) begin
                overrun <= 1'b1;
              end else begin
                rxShift <= {rxShift[22:0], sSdi};
                bitCnt  <= bitCnt + 5'd1;
              end
              if (state == S_HEADER && bitCnt == 5'd7) begin
                regAddr <= {rxShift[5:0], sSdi};
                isRead  <= rxShift[6];
                if (rxShift[6]) begin
                  regRdStrobe <= 1'b1;
                  state       <= S_FETCH;
                end else begin
                  state       <= S_DATA;
                end
              end
            end
            // Strobe cycle, then read data is taken one clk later.
            if (state == S_FETCH) begin
              if (regRdStrobe) begin
                regRdStrobe <= 1'b0;
              end else begin
                txShift <= regRdData;
                state   <= S_DATA;
              end
            end
            // Only reads drive data; writes keep SDO low.
            if (state == S_DATA && shiftEdge && isRead) begin
              SPI_SDO <= txShift[15];
              txShift <= {txShift[14:0], 1'b0};
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_responder.sv
// Randomized scoreboard bench for spi_responder, all four SPI modes.
module tb_spi_responder;

  localparam int H = 4;  // SPI half period in clk cycles (8x oversampling)

  logic clk = 1'b0;
  logic rst_n;
  logic sclk, sdi;
  logic [3:0] csb, sdo, oe, wrS, rdS, busy;
  logic [3:0][6:0]  addr;
  logic [3:0][15:0] wrData;
  logic [3:0][7:0]  errCnt;
  logic [15:0] regRdData;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : gDut
    spi_responder #(.CPOL((g / 2) == 1), .CPHA((g % 2) == 1), .SYNC_STAGES(2)) dut (
      .clk(clk), .rst_n(rst_n),
      .SPI_CLK(sclk), .SPI_CSB(csb[g]), .SPI_SDI(sdi),
      .SPI_SDO(sdo[g]), .SPI_SDO_OE(oe[g]),
      .regAddr(addr[g]), .regRdStrobe(rdS[g]), .regRdData(regRdData),
      .regWrStrobe(wrS[g]), .regWrData(wrData[g]),
      .errorCount(errCnt[g]), .busy(busy[g])
    );
  end

  int nTests = 0;
  int nFail  = 0;
  int mode   = 0;
  int errModel [4];
  int hostStage = 0;

  logic [22:0] expWr[$];
  logic [6:0]  expRd[$];
  logic [15:0] rdValQ[$];
  logic [23:0] expSdo[$];
  logic [23:0] obsSdo[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops expected register-port traffic when the DUT strobes, and
  // plays the host side that answers a read one clk after the strobe.
  always @(negedge clk) begin
    logic [3:0]  sel;
    logic [22:0] ew;
    sel = 4'(1 << mode);
    if (rst_n) begin
      if (((wrS | rdS) & ~sel) != 4'b0)
        chk("stray_strobe", 32'((wrS | rdS) & ~sel), 32'(0));
      if (wrS[mode]) begin
        if (expWr.size() == 0) chk("unexpected_wr", 32'(1), 32'(0));
        else begin
          ew = expWr.pop_front();
          chk("wr_addr", 32'(addr[mode]), 32'(ew[22:16]));
          chk("wr_data", 32'(wrData[mode]), 32'(ew[15:0]));
        end
      end
      if (hostStage == 1) begin
        regRdData = (rdValQ.size() > 0) ? rdValQ.pop_front() : 16'($urandom);
        hostStage = 2;
      end else if (hostStage == 2) begin
        regRdData = 16'($urandom);
        hostStage = 0;
      end
      if (rdS[mode]) begin
        if (expRd.size() == 0) chk("unexpected_rd", 32'(1), 32'(0));
        else chk("rd_addr", 32'(addr[mode]), 32'(expRd.pop_front()));
        hostStage = 1;
      end
    end else begin
      hostStage = 0;
    end
  end

  // SDO checker: compares each captured read frame against its expectation.
  always @(negedge clk) begin
    if (obsSdo.size() > 0) begin
      if (expSdo.size() == 0) chk("unexpected_sdo", 32'(1), 32'(0));
      else chk("sdo_word", 32'(obsSdo.pop_front()), 32'(expSdo.pop_front()));
    end
  end

  task automatic halfWait(input int m, input bit doRst);
    if (doRst) begin
      @(negedge clk); rst_n = 1'b0;
      @(negedge clk);
      chk("rst_strobes_oe", 32'({wrS[m], rdS[m], oe[m], sdo[m], busy[m]}), 32'(0));
      chk("rst_addr_err", 32'({addr[m], errCnt[m]}), 32'(0));
      chk("rst_wrdata", 32'(wrData[m]), 32'(0));
      rst_n = 1'b1;
      repeat (H - 2) @(negedge clk);
    end else begin
      repeat (H) @(negedge clk);
    end
  endtask

  // Bit-bangs one frame of n clocks; SDO captured where the initiator samples.
  task automatic spiFrame(input int m, input int n, input logic [23:0] frame,
                          input int rstBit, output logic [23:0] sdoW, output logic oeMid);
    logic cpol, cpha, b;
    cpol = m[1]; cpha = m[0];
    sdoW = '0; oeMid = 1'b1;
    sclk = cpol;
    csb[m] = 1'b0;
    for (int i = 0; i < n; i++) begin
      b = (i < 24) ? frame[23 - i] : 1'($urandom);
      if (!cpha) begin
        sdi = b;
        halfWait(m, i == rstBit);
        if (i < 24) sdoW[23 - i] = sdo[m];
        if (i == 0) oeMid = oe[m];
        sclk = ~cpol;
        halfWait(m, 1'b0);
        sclk = cpol;
      end else begin
        halfWait(m, i == rstBit);
        sclk = ~cpol;
        sdi = b;
        halfWait(m, 1'b0);
        if (i < 24) sdoW[23 - i] = sdo[m];
        if (i == 0) oeMid = oe[m];
        sclk = cpol;
      end
    end
    halfWait(m, 1'b0);
    csb[m] = 1'b1;
    halfWait(m, 1'b0);
    halfWait(m, 1'b0);
  endtask

  // Reference model: outcome of a frame is decided by its length and R/W bit.
  task automatic runFrame(input int m, input int n, input logic [23:0] frame,
                          input int rstBit, input logic [15:0] rdVal);
    logic [23:0] sdoW;
    logic oeMid;
    logic rw;
    rw = frame[23];
    if (rstBit >= 0) begin
      for (int k = 0; k < 4; k++) errModel[k] = 0;
    end else begin
      if (n >= 8 && rw) begin
        expRd.push_back(frame[22:16]);
        rdValQ.push_back(rdVal);
      end
      if (n == 24) begin
        if (rw) expSdo.push_back({8'h00, rdVal});
        else expWr.push_back({frame[22:16], frame[15:0]});
      end else begin
        errModel[m] = (errModel[m] >= 255) ? 255 : errModel[m] + 1;
      end
    end
    spiFrame(m, n, frame, rstBit, sdoW, oeMid);
    if (rstBit < 0 && n == 24 && rw) obsSdo.push_back(sdoW);
    repeat (2) @(negedge clk);
    chk("frame_pending", 32'(expWr.size() + expRd.size() + expSdo.size()), 32'(0));
    chk("err_count", 32'(errCnt[m]), 32'(errModel[m]));
    chk("idle_oe_busy", 32'({oe[m], busy[m]}), 32'(0));
    if (n > 0 && rstBit != 0) chk("oe_in_frame", 32'(oeMid), 32'(1));
  endtask

  initial begin
    logic [23:0] fr;
    int n;
    rst_n = 1'b0; csb = 4'hF; sclk = 1'b0; sdi = 1'b0; regRdData = '0;
    for (int k = 0; k < 4; k++) errModel[k] = 0;
    repeat (3) @(negedge clk);
    chk("reset_strobes", 32'({wrS, rdS}), 32'(0));
    chk("reset_sdo_oe_busy", 32'({sdo, oe, busy}), 32'(0));
    chk("reset_addr", 32'(addr), 32'(0));
    chk("reset_err", 32'(errCnt), 32'(0));
    rst_n = 1'b1;
    repeat (6) @(negedge clk);

    for (int m = 0; m < 4; m++) begin
      mode = m;
      sclk = m[1];
      repeat (6) @(negedge clk);
      runFrame(m, 24, 24'h051234, -1, 16'h0000);
      chk("addr_hold_wr", 32'(addr[m]), 32'(5));
      runFrame(m, 24, 24'h8A0000, -1, 16'hBEEF);
      chk("addr_hold_rd", 32'(addr[m]), 32'(7'h0A));
      for (int r = 0; r < 6; r++) begin
        fr = 24'($urandom);
        n = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 25)) : 24;
        runFrame(m, n, fr, -1, 16'($urandom));
      end
    end

    // Mode 0 error handling, reset mid-frame and saturation.
    mode = 0; sclk = 1'b0;
    repeat (6) @(negedge clk);
    runFrame(0, 24, 24'h12ABCD, 12, 16'h0000);
    runFrame(0, 24, 24'h3C5A5A, -1, 16'h0000);
    runFrame(0, 16, 24'h051234, -1, 16'h0000);
    runFrame(0, 25, 24'h051234, -1, 16'h0000);
    chk("err_after_two_bad", 32'(errCnt[0]), 32'(2));
    runFrame(0, 24, 24'h7FFFFF, -1, 16'h0000);
    for (int r = 0; r < 260; r++) begin
      n = $urandom_range(0, 23);
      runFrame(0, n, {1'b0, 23'($urandom)}, -1, 16'h0000);
    end
    chk("err_saturated", 32'(errCnt[0]), 32'(255));
    runFrame(0, 24, 24'h05A5A5, -1, 16'h0000);

    repeat (20) @(negedge clk);
    chk("queues_empty", 32'(expWr.size() + expRd.size() + expSdo.size() + obsSdo.size()), 32'(0));
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
